// File: rtl/mips_pkg.sv
// Shared definitions for the program-counter sequencer and its jump-unit
// handshake: decoded path classes, link register index and FSM states.
package mips_pkg;

  localparam logic [3:0] PATH_J   = 4'd5;
  localparam logic [3:0] PATH_JAL = 4'd6;
  localparam logic [3:0] PATH_JR  = 4'd8;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } pcseq_state_t;

  // True for the path classes that are resolved by the jump unit.
  function automatic logic is_jump_path(input logic [3:0] path);
    return (path == PATH_J) || (path == PATH_JAL) || (path == PATH_JR);
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter. A retired instruction either
// advances the PC by one word or hands a jump request to the jump unit,
// waits for completion (bounded by TIMEOUT wait cycles) and loads the
// returned target; jal additionally writes the return address to $ra.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   step, path_index              retire pulse and decoded path class
//   instr_addr, rs_value          j/jal target field, jr register value
//   pc, pc_valid, busy            current PC, RUN indicator, ISSUE/WAIT
//   ju_en, ju_path_index, ju_addr,
//   ju_reg_addr, ju_pc            jump-unit request and operands
//   ju_pc_out, ju_done            jump-unit result and completion flag
//   link_we, link_addr, link_data register-file write port for the link
//   timeout_err                   sticky abandoned-request flag
//   dbg_state                     current FSM state
//
// Handshake: ju_en rises with the operands and holds them stable while it is
// high. ju_done is only honoured in WAIT; the ISSUE cycle gives the jump unit
// one edge to register its result, so a done flag left high from an earlier
// request cannot be mistaken for completion of the new one.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'd0,
  parameter int          TIMEOUT  = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  input  logic [3:0]   path_index,
  input  logic [25:0]  instr_addr,
  input  logic [31:0]  rs_value,
  output logic [31:0]  pc,
  output logic         pc_valid,
  output logic         busy,
  output logic         ju_en,
  output logic [3:0]   ju_path_index,
  output logic [25:0]  ju_addr,
  output logic [31:0]  ju_reg_addr,
  output logic [31:0]  ju_pc,
  input  logic [31:0]  ju_pc_out,
  input  logic         ju_done,
  output logic         link_we,
  output logic [4:0]   link_addr,
  output logic [31:0]  link_data,
  output logic         timeout_err,
  output pcseq_state_t dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

  pcseq_state_t  state_q, state_d;
  logic [CW-1:0] wait_cnt, wait_cnt_d;
  logic [CW-1:0] wait_cnt_inc;
  logic [31:0]   pc_d;
  logic          pc_valid_d, busy_d, ju_en_d;
  logic [3:0]    ju_path_index_d;
  logic [25:0]   ju_addr_d;
  logic [31:0]   ju_reg_addr_d, ju_pc_d;
  logic          link_we_d;
  logic [31:0]   link_data_d;
  logic          timeout_err_d;

  assign wait_cnt_inc = wait_cnt + CW'(1);
  // The link destination never changes; it is a constant, not a data path.
  assign link_addr = REG_RA;
  assign dbg_state = state_q;

  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt;
    pc_d            = pc;
    ju_en_d         = ju_en;
    ju_path_index_d = ju_path_index;
    ju_addr_d       = ju_addr;
    ju_reg_addr_d   = ju_reg_addr;
    ju_pc_d         = ju_pc;
    link_we_d       = 1'b0;
    link_data_d     = link_data;
    timeout_err_d   = timeout_err;

    case (state_q)
      ST_RUN: begin
        if (step) begin
          if (is_jump_path(path_index)) begin
            ju_path_index_d = path_index;
            ju_addr_d       = instr_addr;
            ju_reg_addr_d   = rs_value;
            ju_pc_d         = pc;
            link_data_d     = pc + 32'd1;
            ju_en_d         = 1'b1;
            wait_cnt_d      = '0;
            state_d         = ST_ISSUE;
          end else begin
            pc_d = pc + 32'd1;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ju_done) begin
          pc_d       = ju_pc_out;
          ju_en_d    = 1'b0;
          link_we_d  = (ju_path_index == PATH_JAL);
          wait_cnt_d = '0;
          state_d    = ST_RUN;
        end else if (wait_cnt_inc == CNT_LIMIT) begin
          // Abandon the request: fall through to the next sequential word.
          timeout_err_d = 1'b1;
          pc_d          = ju_pc + 32'd1;
          ju_en_d       = 1'b0;
          wait_cnt_d    = '0;
          state_d       = ST_RUN;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    pc_valid_d = (state_d == ST_RUN);
    busy_d     = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wait_cnt      <= '0;
      pc            <= PC_RESET;
      pc_valid      <= 1'b1;
      busy          <= 1'b0;
      ju_en         <= 1'b0;
      ju_path_index <= 4'd0;
      ju_addr       <= 26'd0;
      ju_reg_addr   <= 32'd0;
      ju_pc         <= 32'd0;
      link_we       <= 1'b0;
      link_data     <= 32'd0;
      timeout_err   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt      <= wait_cnt_d;
      pc            <= pc_d;
      pc_valid      <= pc_valid_d;
      busy          <= busy_d;
      ju_en         <= ju_en_d;
      ju_path_index <= ju_path_index_d;
      ju_addr       <= ju_addr_d;
      ju_reg_addr   <= ju_reg_addr_d;
      ju_pc         <= ju_pc_d;
      link_we       <= link_we_d;
      link_data     <= link_data_d;
      timeout_err   <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer paired with a behavioural jump unit.
// Jump-unit modes: 0 = done on first ju_en edge, 1 = done never asserted,
// 2 = done held high (stale flag), target still registered on ju_en rise.
module tb_pc_sequencer;
  import mips_pkg::*;

  localparam logic [31:0] PC_RST = 32'd0;
  localparam int          TMO    = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         step = 1'b0;
  logic [3:0]   path_index = 4'd0;
  logic [25:0]  instr_addr = 26'd0;
  logic [31:0]  rs_value = 32'd0;
  logic [31:0]  pc;
  logic         pc_valid, busy, ju_en;
  logic [3:0]   ju_path_index;
  logic [25:0]  ju_addr;
  logic [31:0]  ju_reg_addr, ju_pc;
  logic [31:0]  ju_pc_out = 32'd0;
  logic         ju_done = 1'b0;
  logic         link_we;
  logic [4:0]   link_addr;
  logic [31:0]  link_data;
  logic         timeout_err;
  pcseq_state_t dbg_state;

  int           checks = 0;
  int           errors = 0;
  int           ju_mode = 0;
  logic         ju_en_q = 1'b0;
  logic [31:0]  exp_pc;
  logic [31:0]  exp_q[$];

  pc_sequencer #(.PC_RESET(PC_RST), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .path_index(path_index),
    .instr_addr(instr_addr), .rs_value(rs_value), .pc(pc), .pc_valid(pc_valid),
    .busy(busy), .ju_en(ju_en), .ju_path_index(ju_path_index), .ju_addr(ju_addr),
    .ju_reg_addr(ju_reg_addr), .ju_pc(ju_pc), .ju_pc_out(ju_pc_out),
    .ju_done(ju_done), .link_we(link_we), .link_addr(link_addr),
    .link_data(link_data), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Behavioural jump unit
  always @(posedge clk) begin
    ju_en_q <= ju_en;
    if (ju_en && !ju_en_q)
      ju_pc_out <= (ju_path_index == PATH_JR) ? ju_reg_addr : {ju_pc[31:26], ju_addr};
    case (ju_mode)
      1:       ju_done <= 1'b0;
      2:       ju_done <= 1'b1;
      default: ju_done <= ju_en && (ju_done || !ju_en_q);
    endcase
  end

  // Driver: one sequential step, expected pc pushed at drive, popped next cycle.
  task automatic seq_step(input logic [3:0] p);
    logic [31:0] want;
    @(negedge clk);
    step = 1'b1; path_index = p;
    exp_q.push_back(exp_pc + 32'd1);
    @(negedge clk);
    step = 1'b0; path_index = 4'd0;
    want = exp_q.pop_front();
    checks++;
    if (pc !== want) begin
      errors++; $display("FAIL seq_pc got %h want %h", pc, want);
    end
    exp_pc = want;
  endtask

  // Driver: one jump request, followed until the DUT is back in RUN.
  task automatic run_jump(input logic [3:0] p, input logic [25:0] a, input logic [31:0] rs,
                          input logic [31:0] target, input bit exp_link,
                          input int exp_en, input bit poke);
    logic [31:0] start_pc, want;
    int en_cycles, links, cycles;
    bit stable;
    @(negedge clk);
    step = 1'b1; path_index = p; instr_addr = a; rs_value = rs;
    start_pc = exp_pc;
    exp_q.push_back(target);
    @(negedge clk);
    step = 1'b0; path_index = 4'd0;
    checks++;
    if (busy !== 1'b1 || pc_valid !== 1'b0) begin
      errors++; $display("FAIL issue_busy got busy=%b pc_valid=%b want 1/0", busy, pc_valid);
    end
    checks++;
    if (ju_pc !== start_pc || ju_path_index !== p || ju_addr !== a || ju_reg_addr !== rs) begin
      errors++;
      $display("FAIL operands got pc=%h path=%0d addr=%h reg=%h want %h %0d %h %h",
               ju_pc, ju_path_index, ju_addr, ju_reg_addr, start_pc, p, a, rs);
    end
    en_cycles = 0; links = 0; cycles = 0; stable = 1'b1;
    while (!pc_valid && cycles < 40) begin
      if (ju_en) en_cycles++;
      if (link_we) links++;
      if (ju_pc !== start_pc || ju_addr !== a || ju_path_index !== p || ju_reg_addr !== rs)
        stable = 1'b0;
      step = poke; path_index = 4'd0;
      @(negedge clk);
      cycles++;
    end
    step = 1'b0;
    checks++;
    if (!pc_valid) begin
      errors++; $display("FAIL jump_budget got busy after %0d cycles want RUN", cycles);
    end
    want = exp_q.pop_front();
    checks++;
    if (pc !== want) begin
      errors++; $display("FAIL jump_pc got %h want %h", pc, want);
    end
    checks++;
    if (en_cycles != exp_en || ju_en !== 1'b0) begin
      errors++; $display("FAIL ju_en_len got %0d cycles (now %b) want %0d", en_cycles, ju_en, exp_en);
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL operand_hold got unstable want stable");
    end
    checks++;
    if (link_we !== exp_link || links != 0) begin
      errors++; $display("FAIL link_we got %b (early %0d) want %b", link_we, links, exp_link);
    end
    if (exp_link) begin
      checks++;
      if (link_addr !== 5'd31 || link_data !== start_pc + 32'd1) begin
        errors++; $display("FAIL link_val got %0d/%h want 31/%h", link_addr, link_data, start_pc + 32'd1);
      end
    end
    @(negedge clk);
    checks++;
    if (link_we !== 1'b0 || pc !== want) begin
      errors++; $display("FAIL post_jump got we=%b pc=%h want 0/%h", link_we, pc, want);
    end
    exp_pc = want;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_pc = PC_RST;
    checks++;
    if (pc !== PC_RST || pc_valid !== 1'b1 || ju_en !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_ctl got pc=%h v=%b en=%b busy=%b want %h 1 0 0", pc, pc_valid, ju_en, busy, PC_RST);
    end
    checks++;
    if (link_we !== 1'b0 || link_addr !== 5'd31 || link_data !== 32'd0 || timeout_err !== 1'b0 ||
        ju_pc !== 32'd0 || ju_addr !== 26'd0 || ju_reg_addr !== 32'd0 || ju_path_index !== 4'd0) begin
      errors++; $display("FAIL reset_ops got we=%b la=%0d ld=%h te=%b jpc=%h want 0 31 0 0 0", link_we, link_addr, link_data, timeout_err, ju_pc);
    end
    repeat (3) seq_step(4'd0);
    checks++;
    if (pc !== 32'd3) begin
      errors++; $display("FAIL three_steps got %h want 00000003", pc);
    end
  endtask

  task automatic test_j();
    ju_mode = 0;
    run_jump(PATH_JR, 26'd0, 32'h0000_0010, 32'h0000_0010, 1'b0, 2, 1'b0);
    run_jump(PATH_J, 26'h0000123, 32'd0, 32'h0000_0123, 1'b0, 2, 1'b0);
  endtask

  task automatic test_jal();
    ju_mode = 0;
    run_jump(PATH_JR, 26'd0, 32'h4000_0008, 32'h4000_0008, 1'b0, 2, 1'b0);
    run_jump(PATH_JAL, 26'h0000040, 32'd0, 32'h4000_0040, 1'b1, 2, 1'b0);
  endtask

  task automatic test_stale_done();
    ju_mode = 2;
    repeat (2) @(negedge clk);
    run_jump(PATH_JR, 26'd0, 32'h0000_0200, 32'h0000_0200, 1'b0, 2, 1'b1);
    ju_mode = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    ju_mode = 1;
    run_jump(PATH_J, 26'h0000055, 32'd0, exp_pc + 32'd1, 1'b0, TMO + 1, 1'b0);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_set got %b want 1", timeout_err);
    end
    ju_mode = 0;
    seq_step(4'd1);
    seq_step(4'd7);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky got %b want 1", timeout_err);
    end
  endtask

  task automatic test_reset_in_wait();
    ju_mode = 1;
    @(negedge clk);
    step = 1'b1; path_index = PATH_J; instr_addr = 26'h0000777;
    @(negedge clk);
    step = 1'b0; path_index = 4'd0;
    @(negedge clk);
    checks++;
    if (dbg_state !== ST_WAIT) begin
      errors++; $display("FAIL reach_wait got %0d want %0d", dbg_state, ST_WAIT);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = PC_RST;
    checks++;
    if (pc !== PC_RST || ju_en !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0 || link_data !== 32'd0) begin
      errors++; $display("FAIL wait_reset got pc=%h en=%b busy=%b te=%b want %h 0 0 0", pc, ju_en, busy, timeout_err, PC_RST);
    end
    ju_mode = 2;
    repeat (3) @(negedge clk);
    checks++;
    if (pc !== PC_RST || pc_valid !== 1'b1) begin
      errors++; $display("FAIL late_done got pc=%h v=%b want %h 1", pc, pc_valid, PC_RST);
    end
    ju_mode = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wrap();
    ju_mode = 0;
    run_jump(PATH_JR, 26'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2, 1'b0);
    seq_step(4'd0);
    checks++;
    if (pc !== 32'd0) begin
      errors++; $display("FAIL wrap got %h want 00000000", pc);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  p;
    logic [25:0] a;
    logic [31:0] r;
    ju_mode = 0;
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 2))
        0: begin
          p = 4'($urandom_range(0, 15));
          if (is_jump_path(p)) p = 4'd0;
          seq_step(p);
        end
        1: begin
          r = $urandom;
          run_jump(PATH_JR, 26'd0, r, r, 1'b0, 2, 1'b0);
        end
        default: begin
          a = 26'($urandom);
          run_jump(PATH_JAL, a, 32'd0, {exp_pc[31:26], a}, 1'b1, 2, 1'b0);
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_j();
    test_jal();
    test_stale_done();
    test_timeout();
    test_reset_in_wait();
    test_wrap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Owns the program counter and is the requesting side of the jump unit handshake. On every retired instruction it either advances the PC by one word, or it issues a request to the jump unit and waits for the completion flag. It then loads the returned target and, for jump-and-link, writes the return address to `$ra`. It sits between decode/control and instruction fetch.

## Interface
Parameters:
- `PC_RESET`, default 32'd0: PC value after reset.
- `TIMEOUT`, default 15: maximum number of WAIT cycles before the request is abandoned. Must be at least 1.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `step` in 1: instruction retire pulse. Sampled only in RUN.
- `path_index` in 4: decoded class. 5 = j, 6 = jal, 8 = jr, any other value = sequential.
- `instr_addr` in 26: target field for j/jal.
- `rs_value` in 32: register value for jr.
- `pc` out 32: current PC.
- `pc_valid` out 1: high only in RUN.
- `busy` out 1: high in ISSUE or WAIT.
- `ju_en` out 1: jump unit enable.
- `ju_path_index` out 4, `ju_addr` out 26, `ju_reg_addr` out 32, `ju_pc` out 32: request operands.
- `ju_pc_out` in 32: target returned by the jump unit.
- `ju_done` in 1: completion flag from the jump unit.
- `link_we` out 1, `link_addr` out 5, `link_data` out 32: register-file write port for the link value.
- `timeout_err` out 1: sticky error flag.

## Operation
- States: RUN, ISSUE, WAIT.
- RUN with `step` and `path_index` in {5, 6, 8}:
  - Latch `ju_path_index`, `ju_addr`, `ju_reg_addr` and `ju_pc = pc`.
  - Latch `link_data = pc + 1`.
  - Set `ju_en` to 1 and go to ISSUE.
- RUN with `step` and any other path: `pc <= pc + 1`, stay in RUN.
- RUN without `step`: hold.
- ISSUE: unconditionally go to WAIT. `ju_done` is ignored here because it may be stale from the previous request.
- WAIT with `ju_done = 1`:
  - `pc <= ju_pc_out`, `ju_en <= 0`, go to RUN.
  - If the latched path is 6, pulse `link_we` for exactly one cycle with `link_addr = 31`.
- WAIT with `ju_done = 0`:
  - Increment the wait counter.
  - When the counter reaches `TIMEOUT`, set `timeout_err`, do `pc <= ju_pc + 1`, clear `ju_en`, go to RUN. No link write.
- `step` is ignored while `busy` is high.
- Arithmetic: PC increment is word-granular (+1) and wraps modulo 2^32, so 0xFFFF_FFFF becomes 0.
- `timeout_err` stays set until reset.
- Reset values:
  - `pc` = `PC_RESET`.
  - State = RUN.
  - `pc_valid` = 1, `busy` = 0, `ju_en` = 0.
  - All `ju_*` operand outputs = 0.
  - `link_we` = 0, `link_addr` = 31, `link_data` = 0.
  - `timeout_err` = 0.
  - Wait counter = 0.
- Reset asserted in ISSUE or WAIT: the next edge forces the reset values. A late `ju_done` is ignored because the state is RUN.

## Timing
- Sequential step: `step` in cycle t gives the new `pc` in cycle t+1.
- Jump: `step` in cycle t.
  - `ju_en` is high in cycles t+1 (ISSUE) and t+2 (first WAIT).
  - The jump unit registers its result at the end of t+1.
  - With `ju_done` high in t+2: new `pc` and `pc_valid` = 1 in t+3, `ju_en` = 0 in t+3, `link_we` high in t+3 only (jal).
- Minimum jump latency is 3 cycles. Maximum is 2 + `TIMEOUT` cycles.
- Operand outputs hold stable for the whole time `ju_en` is high.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- Shared package `mips_pkg`:
  - `PATH_J` = 4'd5, `PATH_JAL` = 4'd6, `PATH_JR` = 4'd8.
  - `REG_RA` = 5'd31.
  - State enum `pcseq_state_t`.
- Single flat module. The wait counter is inline (width $clog2(TIMEOUT+1)), with no sub-module.
- The bench pairs this block with a behavioural jump-unit model. The model sets done on the first `ju_en` edge, can have done forced low to create a timeout, and can have done held high between requests (stale flag).

## Test plan
- Reset with `PC_RESET` = 0: `pc` = 0, `pc_valid` = 1, `ju_en` = 0. Three sequential `step`s (path 0) give `pc` = 3.
- j: `pc` = 0x0000_0010, `step` with path 5 and `instr_addr` = 0x0000123. `ju_en` is high for exactly 2 cycles, then `pc` = 0x0000_0123 at t+3, `link_we` never pulses.
- jal: `pc` = 0x4000_0008, path 6, `instr_addr` = 0x0000040. Result: `pc` = 0x4000_0040, and a single `link_we` pulse with `link_addr` = 31 and `link_data` = 0x4000_0009.
- jr with stale done: `ju_done` held at 1 before the request, `rs_value` = 0x0000_0200, path 8. ISSUE still lasts one cycle, `pc` = 0x0000_0200. A `step` pulsed during ISSUE/WAIT has no effect.
- Timeout: `TIMEOUT` = 4 and the model never asserts done. After 4 WAIT cycles `timeout_err` = 1, `pc` = old `pc` + 1, RUN. The flag stays set through further steps until `rst_n` = 0.
- Reset in WAIT: `pc` returns to `PC_RESET` and `ju_en` = 0 on the next edge, and a later `ju_done` does not change `pc`. Wrap: `pc` = 0xFFFF_FFFF plus a sequential `step` gives `pc` = 0.
